tile_fetch: RTL and testbench

- Text/tile-mode pixel source for the VGA path.
- Sits between the VGA timing controller (h_count/v_count/sync/bright) and the RGB output pins.
- For each 8-pixel tile it prefetches a tile-map word and a glyph row from a shared 16-bit synchronous memory, then shifts the glyph row out pixel by pixel, colouring it through a 16-entry palette.
- Sync and bright are delayed to stay aligned with rgb.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/glyph_shifter.sv | 51 +++++
 rtl/tile_fetch.sv | 131 +++++++++++++
 tb/tb_tile_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA pixel path.
//   - 8-bit RRR_GGG_BB colour constants and the 16-entry tile palette
//   - tile-map word layout (glyph index / fg / bg palette indices)
//   - default word addresses of the tile map and glyph table
package vga_pkg;

    localparam logic [7:0] BLACK     = 8'h00;
    localparam logic [7:0] BLUE      = 8'h03;
    localparam logic [7:0] GREEN     = 8'h1C;
    localparam logic [7:0] CYAN      = 8'h1F;
    localparam logic [7:0] RED       = 8'hE0;
    localparam logic [7:0] MAGENTA   = 8'hE3;
    localparam logic [7:0] YELLOW    = 8'hFC;
    localparam logic [7:0] WHITE     = 8'hFF;
    localparam logic [7:0] GREY      = 8'h92;
    localparam logic [7:0] DARK_GREY = 8'h49;
    localparam logic [7:0] TEAL      = 8'h13;
    localparam logic [7:0] LIME      = 8'h7C;
    localparam logic [7:0] SKY       = 8'h9F;
    localparam logic [7:0] ORANGE    = 8'hE8;
    localparam logic [7:0] PINK      = 8'hEF;
    localparam logic [7:0] GOLD      = 8'hF4;

    // Entry 15 first: packed array, index 0 is the least significant byte.
    localparam logic [15:0][7:0] PALETTE = {
        WHITE, GOLD, PINK, ORANGE, SKY, LIME, TEAL, DARK_GREY,
        GREY, YELLOW, MAGENTA, RED, CYAN, GREEN, BLUE, BLACK
    };

    // Tile-map word: [15:8] glyph index, [7:4] fg index, [3:0] bg index.
    localparam int MAP_GLYPH_LSB = 8;
    localparam int MAP_FG_LSB    = 4;
    localparam int MAP_BG_LSB    = 0;

    typedef struct packed {
        logic [7:0] glyph;
        logic [3:0] fg;
        logic [3:0] bg;
    } map_word_t;

    localparam logic [15:0] MAP_BASE_DEF   = 16'h4000;
    localparam logic [15:0] GLYPH_BASE_DEF = 16'h5000;

endpackage

// File: rtl/glyph_shifter.sv
// glyph_shifter: 8-bit glyph-row shift register with fg/bg palette latch.
// Ports:
//   clk        pixel clock
//   i_clear    synchronous active-high reset
//   i_load     load pattern/fg/bg this cycle instead of shifting
//   i_bright   visible-region flag; rgb forced to 0 when low
//   i_pattern  next glyph row, MSB = leftmost pixel
//   i_fg/i_bg  palette indices for set/clear pixels
//   o_rgb      registered RRR_GGG_BB colour
module glyph_shifter
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_bright,
    input  logic [7:0] i_pattern,
    input  logic [3:0] i_fg,
    input  logic [3:0] i_bg,
    output logic [7:0] o_rgb
);

    logic [7:0] r_shift;
    logic [3:0] r_fg;
    logic [3:0] r_bg;
    logic [7:0] r_rgb;
    logic       w_bit;

    assign w_bit = r_shift[7];
    assign o_rgb = r_rgb;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_shift <= 8'd0;
            r_fg    <= 4'd0;
            r_bg    <= 4'd0;
            r_rgb   <= 8'd0;
        end else begin
            // The load cycle still emits the last pixel of the outgoing tile.
            r_rgb <= i_bright ? (w_bit ? PALETTE[r_fg] : PALETTE[r_bg]) : 8'd0;
            if (i_load) begin
                r_shift <= i_pattern;
                r_fg    <= i_fg;
                r_bg    <= i_bg;
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/tile_fetch.sv
// tile_fetch: text/tile-mode pixel source between the VGA timing controller
// and the RGB pins. For each 8-pixel tile it prefetches a tile-map word and a
// glyph row from a shared 16-bit synchronous memory one tile ahead, then
// shifts the glyph row out through the palette.
// Ports:
//   clk, clear             pixel clock, synchronous active-high reset
//   h_count, v_count       counters from the timing controller
//   h_sync_in, v_sync_in   syncs from the controller
//   bright_in              visible-region flag from the controller
//   mem_data               read data, valid one cycle after mem_rd
//   mem_rd, mem_addr       registered read strobe and word address
//   rgb                    registered RRR_GGG_BB colour
//   h_sync, v_sync, bright inputs delayed one cycle to line up with rgb
module tile_fetch
    import vga_pkg::*;
#(
    parameter int          HSTART     = 144,
    parameter int          VSTART     = 31,
    parameter int          HVID       = 640,
    parameter int          VVID       = 480,
    parameter int          COLS       = 80,
    parameter logic [15:0] MAP_BASE   = MAP_BASE_DEF,
    parameter logic [15:0] GLYPH_BASE = GLYPH_BASE_DEF
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        bright_in,
    input  logic [15:0] mem_data,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [7:0]  rgb,
    output logic        h_sync,
    output logic        v_sync,
    output logic        bright
);

    logic [9:0]  w_fx;
    logic [9:0]  w_y;
    logic        w_win;
    logic [6:0]  w_col;
    logic [2:0]  w_phase;
    logic [15:0] w_trow16;
    logic [15:0] w_map_addr;
    logic [15:0] w_glyph_addr;
    logic        w_load;

    logic        r_mem_rd;
    logic [15:0] r_mem_addr;
    map_word_t   r_map_next;
    logic [7:0]  r_pattern_next;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_bright;

    // Fetch runs one tile (8 pixels) ahead of display; counter wrap is left
    // to the unsigned compares.
    assign w_fx    = h_count - 10'(HSTART - 8);
    assign w_y     = v_count - 10'(VSTART);
    assign w_win   = (w_fx < 10'(HVID)) && (w_y < 10'(VVID));
    assign w_col   = w_fx[9:3];
    assign w_phase = w_fx[2:0];

    // Row offset as shift-add: trow*80 = trow*64 + trow*16 (COLS is 80).
    assign w_trow16   = {10'd0, w_y[8:3]};
    assign w_map_addr = MAP_BASE + (w_trow16 << 6) + (w_trow16 << 4) + {9'd0, w_col};

    // Glyph index comes straight off mem_data: the map word arrives in the
    // same cycle the glyph read must be issued.
    assign w_glyph_addr = GLYPH_BASE
                        + {6'd0, mem_data[MAP_GLYPH_LSB +: 8], 2'b00}
                        + {14'd0, w_y[2:1]};

    assign w_load = w_win && (w_phase == 3'd7);

    always_ff @(posedge clk) begin
        if (clear) begin
            r_mem_rd       <= 1'b0;
            r_mem_addr     <= 16'd0;
            r_map_next     <= '0;
            r_pattern_next <= 8'd0;
            r_h_sync       <= 1'b1;
            r_v_sync       <= 1'b1;
            r_bright       <= 1'b0;
        end else begin
            r_h_sync <= h_sync_in;
            r_v_sync <= v_sync_in;
            r_bright <= bright_in;
            r_mem_rd <= 1'b0;
            if (w_win) begin
                case (w_phase)
                    3'd0: begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_map_addr;
                    end
                    3'd2: begin
                        r_map_next <= mem_data;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_glyph_addr;
                    end
                    3'd4: begin
                        // Even lines use the high byte, odd lines the low byte.
                        r_pattern_next <= w_y[0] ? mem_data[7:0] : mem_data[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign h_sync   = r_h_sync;
    assign v_sync   = r_v_sync;
    assign bright   = r_bright;

    glyph_shifter u_shifter (
        .clk       (clk),
        .i_clear   (clear),
        .i_load    (w_load),
        .i_bright  (bright_in),
        .i_pattern (r_pattern_next),
        .i_fg      (r_map_next.fg),
        .i_bg      (r_map_next.bg),
        .o_rgb     (rgb)
    );

endmodule

// File: tb/tb_tile_fetch.sv
module tb_tile_fetch;

    logic        clk = 1'b0;
    logic        clear;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        bright_in;
    logic [15:0] mem_data;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  rgb;
    logic        h_sync;
    logic        v_sync;
    logic        bright;

    always #5 clk = ~clk;

    tile_fetch dut (
        .clk       (clk),
        .clear     (clear),
        .h_count   (h_count),
        .v_count   (v_count),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .bright_in (bright_in),
        .mem_data  (mem_data),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .rgb       (rgb),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .bright    (bright)
    );

    // ---------------- memory contents (filled lazily, random) ----------------
    logic [15:0] mem_store [int];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (!mem_store.exists(int'(a)))
            mem_store[int'(a)] = 16'($urandom);
        return mem_store[int'(a)];
    endfunction

    // Synchronous read port: data one cycle after the strobe, junk otherwise.
    always @(posedge clk)
        mem_data <= mem_rd ? mem_word(mem_addr) : 16'($urandom);

    // ---------------- reference model ----------------
    function automatic logic [7:0] pal(input logic [3:0] i);
        case (i)
            4'd0:  return 8'h00;
            4'd1:  return 8'h03;
            4'd2:  return 8'h1C;
            4'd3:  return 8'h1F;
            4'd4:  return 8'hE0;
            4'd5:  return 8'hE3;
            4'd6:  return 8'hFC;
            4'd7:  return 8'h92;
            4'd8:  return 8'h49;
            4'd9:  return 8'h13;
            4'd10: return 8'h7C;
            4'd11: return 8'h9F;
            4'd12: return 8'hE8;
            4'd13: return 8'hEF;
            4'd14: return 8'hF4;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] map_addr(input int trow, input int col);
        return 16'h4000 + 16'(trow * 80 + col);
    endfunction

    typedef struct {
        int          line_id;
        int          h;
        bit          chk_rgb;
        logic [7:0]  rgb;
        bit          chk_addr;
        logic        mem_rd;
        logic [15:0] addr;
        logic        hs;
        logic        vs;
        logic        br;
    } exp_t;

    exp_t exp_q[$];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cur_line = 0;
    int          seg_start = 100000;   // fx of first edge of current line run
    int          rst_fx = -1000;       // fx of a clear inside the current run
    logic [15:0] m_addr = 16'd0;
    bit          m_addr_known = 1'b0;

    // Drive one clock's inputs and queue the outputs they must produce.
    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic br,
                         input logic hs, input logic vs, input logic clr);
        exp_t        e;
        int          fx, hp, c, px, y;
        logic [9:0]  fxw, yw;
        logic        win;
        logic [15:0] mw, gw;
        logic [7:0]  pat;

        fx  = int'(h) - 136;
        fxw = h - 10'd136;
        yw  = v - 10'd31;
        y   = int'(yw);
        win = (fxw < 10'd640) && (yw < 10'd480);

        e.line_id = cur_line;
        e.h       = int'(h);
        e.chk_rgb = 1'b1;
        e.rgb     = 8'd0;
        e.mem_rd  = 1'b0;

        if (clr) begin
            e.hs = 1'b1; e.vs = 1'b1; e.br = 1'b0;
            m_addr = 16'd0; m_addr_known = 1'b1;
            rst_fx = fx;
        end else begin
            e.hs = hs; e.vs = vs; e.br = br;
            if (win && fxw[2:0] == 3'd0) begin
                e.mem_rd = 1'b1;
                m_addr = map_addr(y / 8, int'(fxw) / 8);
                m_addr_known = 1'b1;
            end else if (win && fxw[2:0] == 3'd2) begin
                e.mem_rd = 1'b1;
                if (fx - 2 >= seg_start && rst_fx != fx - 2) begin
                    mw = mem_word(map_addr(y / 8, int'(fxw) / 8));
                    m_addr = 16'h5000 + 16'(mw[15:8]) * 16'd4 + 16'(yw[2:1]);
                    m_addr_known = 1'b1;
                end else begin
                    m_addr_known = 1'b0;
                end
            end
            if (br) begin
                hp = int'(h) - 144;
                c  = hp / 8;
                px = hp % 8;
                if (hp < 0 || hp >= 640 || yw >= 10'd480 || 8 * c < seg_start) begin
                    e.chk_rgb = 1'b0;
                end else if (rst_fx >= 8 * c + 8) begin
                    e.rgb = pal(4'd0);
                end else if (rst_fx >= 8 * c && rst_fx != 8 * c + 1) begin
                    e.chk_rgb = 1'b0;
                end else begin
                    mw  = mem_word(map_addr(y / 8, c));
                    gw  = mem_word(16'h5000 + 16'(mw[15:8]) * 16'd4 + 16'(yw[2:1]));
                    pat = yw[0] ? gw[7:0] : gw[15:8];
                    e.rgb = pat[7 - px] ? pal(mw[7:4]) : pal(mw[3:0]);
                end
            end
        end
        e.chk_addr = m_addr_known;
        e.addr     = m_addr;
        exp_q.push_back(e);

        h_count = h; v_count = v; bright_in = br;
        h_sync_in = hs; v_sync_in = vs; clear = clr;
        @(posedge clk);
        #1;
    endtask

    // One contiguous run of h on a line; clr_h < 0 means no clear.
    task automatic run_line(input int v, input int h0, input int h1,
                            input int clr_h, input bit drop_bright);
        logic br;
        cur_line++;
        seg_start = h0 - 136;
        rst_fx = -1000;
        for (int h = h0; h <= h1; h++) begin
            br = (h >= 144 && h < 784 && v >= 31 && v < 511);
            if (drop_bright && ($urandom_range(0, 15) == 0)) br = 1'b0;
            drive(10'(h), 10'(v), br, 1'($urandom), 1'($urandom), h == clr_h);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input exp_t e, input string name,
                       input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL line%0d h=%0d %s: got %h expected %h",
                     e.line_id, e.h, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e, "mem_rd", 16'(mem_rd), 16'(e.mem_rd));
            cmp(e, "h_sync", 16'(h_sync), 16'(e.hs));
            cmp(e, "v_sync", 16'(v_sync), 16'(e.vs));
            cmp(e, "bright", 16'(bright), 16'(e.br));
            if (e.chk_addr) cmp(e, "mem_addr", mem_addr, e.addr);
            if (e.chk_rgb)  cmp(e, "rgb", 16'(rgb), 16'(e.rgb));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        h_count = '0; v_count = '0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        bright_in = 1'b0; clear = 1'b1;

        // Directed memory contents.
        mem_store[32'h4000] = 16'h0AF0;   // glyph 0x0A, fg WHITE, bg BLACK
        mem_store[32'h5028] = 16'h8100;
        mem_store[32'h404F] = 16'h0140;   // glyph 1, fg RED, bg BLACK
        mem_store[32'h5004] = 16'hFF00;

        // Reset with arbitrary inputs.
        for (int i = 0; i < 3; i++)
            drive(10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b1);

        run_line(31, 136, 160, -1, 1'b0);   // first tile: W,B x6,W
        run_line(32, 136, 160, -1, 1'b0);   // odd row: low byte -> all BLACK
        run_line(39, 136, 150, -1, 1'b0);   // tile row 1: map 0x4050
        run_line(511, 0, 799, -1, 1'b0);    // y = 480: no reads at all
        run_line(31, 768, 790, -1, 1'b0);   // last column, RED then 0
        run_line(31, 136, 170, 145, 1'b0);  // mid-line clear

        for (int i = 0; i < 12; i++)
            run_line($urandom_range(20, 520), $urandom_range(100, 140), 799, -1, 1'b1);

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
